// File: rtl/serial_to_parallel.sv
// serial_to_parallel
// Collects a framed serial bitstream into an N-bit word and presents each
// completed word on data_out together with a one-cycle load pulse. It sits
// in front of an N-bit loadable register, so load/data_out map onto that
// register's load/data_in pair. A start strobe in the middle of a frame
// aborts it. The abort is flagged with err and the partial word is dropped.
// All outputs are registered.

module serial_to_parallel #(
   parameter int N         = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         sin,
   input  logic         sin_en,
   output logic [N-1:0] data_out,
   output logic         load,
   output logic         busy,
   output logic         err
);

   // cnt must represent 0..N-1 in SHIFT. N+1 gives headroom so the compare
   // against N-1 never needs a wider operand.
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [N-1:0]    shreg;
   logic [N-1:0]    shreg_nxt;
   logic [N-1:0]    shifted;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic [N-1:0]    data_nxt;
   logic            load_nxt;
   logic            err_nxt;
   logic            busy_nxt;
   logic            last_bit;

   // The bit sampled at the Nth edge completes the word.
   assign last_bit = (cnt == CW'(N - 1));

   // Shift direction decides where the first received bit ends up.
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign shifted = {shreg[N-2:0], sin};
      end else begin : g_lsb_first
         assign shifted = {sin, shreg[N-1:1]};
      end
   endgenerate

   // State register.
   // NOTE: clocked blocks use non-blocking (<=) so every flop samples the
   // pre-edge values of the others. Blocking here would create ordering races.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. A start strobe always wins and opens a fresh frame.
   // NOTE: state_nxt gets a default before the case so that no path leaves
   // it unassigned. Without the default, synthesis would infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (start) begin
               state_nxt = SHIFT;
            end else if (sin_en && last_bit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = start ? SHIFT : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output / datapath logic. It computes the next value of every registered
   // output and of the shift register and bit counter.
   always_comb begin
      shreg_nxt = shreg;
      cnt_nxt   = cnt;
      data_nxt  = data_out;
      load_nxt  = 1'b0;
      err_nxt   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               shreg_nxt = '0;
               cnt_nxt   = '0;
            end
         end
         SHIFT: begin
            if (start) begin
               // Abort: drop the partial word and leave data_out alone.
               shreg_nxt = '0;
               cnt_nxt   = '0;
               err_nxt   = 1'b1;
            end else if (sin_en) begin
               shreg_nxt = shifted;
               if (last_bit) begin
                  data_nxt = shifted;
                  load_nxt = 1'b1;
                  cnt_nxt  = '0;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
         end
         DONE: begin
            if (start) begin
               shreg_nxt = '0;
               cnt_nxt   = '0;
            end
         end
         default: begin
            shreg_nxt = '0;
            cnt_nxt   = '0;
         end
      endcase
      busy_nxt = (state_nxt == SHIFT);
   end

   // Datapath and output registers.
   // NOTE: shreg is cleared on reset even though every frame clears it at
   // start. A defined value after reset keeps a discarded partial word from
   // ever being observable.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg    <= '0;
         cnt      <= '0;
         data_out <= '0;
         load     <= 1'b0;
         err      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         shreg    <= shreg_nxt;
         cnt      <= cnt_nxt;
         data_out <= data_nxt;
         load     <= load_nxt;
         err      <= err_nxt;
         busy     <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Testbench for serial_to_parallel. The first two DUTs are 8-bit: one is
// MSB-first and one is LSB-first, and both take the same stimulus. The third
// DUT is 4-bit and LSB-first. A reference loadable register is chained
// behind the MSB-first DUT. Expected words are queued when a frame is
// issued, and a negedge monitor pops and compares each one on every load.

module tb_serial_to_parallel;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_a = 1'b0, sin_a = 1'b0, en_a = 1'b0;
   logic       start_c = 1'b0, sin_c = 1'b0, en_c = 1'b0;
   logic [7:0] data_a, data_b;
   logic [3:0] data_c;
   logic       load_a, busy_a, err_a;
   logic       load_b, busy_b, err_b;
   logic       load_c, busy_c, err_c;
   logic [7:0] reg_q;
   logic       rst_q;

   int errors = 0;
   int checks = 0;
   int n_load_a = 0, n_load_b = 0, n_load_c = 0, n_err_a = 0;
   bit started = 1'b0;

   logic [7:0] exp_a[$];
   logic [7:0] exp_b[$];
   logic [3:0] exp_c[$];

   always #5 clk = ~clk;

   serial_to_parallel #(.N(8), .MSB_FIRST(1'b1)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .sin(sin_a), .sin_en(en_a),
      .data_out(data_a), .load(load_a), .busy(busy_a), .err(err_a));

   serial_to_parallel #(.N(8), .MSB_FIRST(1'b0)) dut_b (
      .clk(clk), .rst(rst), .start(start_a), .sin(sin_a), .sin_en(en_a),
      .data_out(data_b), .load(load_b), .busy(busy_b), .err(err_b));

   serial_to_parallel #(.N(4), .MSB_FIRST(1'b0)) dut_c (
      .clk(clk), .rst(rst), .start(start_c), .sin(sin_c), .sin_en(en_c),
      .data_out(data_c), .load(load_c), .busy(busy_c), .err(err_c));

   // Downstream 8-bit loadable register fed by dut_a.
   always @(posedge clk) begin
      rst_q <= rst;
      if (rst) reg_q <= 8'h00;
      else if (load_a) reg_q <= data_a;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor.
   logic       load_a_prev = 1'b0, err_a_prev = 1'b0;
   logic [7:0] data_a_prev = 8'h00;
   always @(negedge clk) begin
      if (started) begin
         if (load_a) begin
            n_load_a++;
            if (exp_a.size() == 0) check("load_a_unexpected", 32'(load_a), 0);
            else check("data_a", 32'(data_a), 32'(exp_a.pop_front()));
            check("load_err_overlap_a", 32'(err_a), 0);
            check("load_width_a", 32'(load_a_prev), 0);
         end
         if (err_a) begin
            n_err_a++;
            check("err_width_a", 32'(err_a_prev), 0);
         end
         if (data_a != data_a_prev && !load_a && !rst_q)
            check("data_stable_a", 32'(data_a), 32'(data_a_prev));
         if (load_b) begin
            n_load_b++;
            if (exp_b.size() == 0) check("load_b_unexpected", 32'(load_b), 0);
            else check("data_b", 32'(data_b), 32'(exp_b.pop_front()));
         end
         if (load_c) begin
            n_load_c++;
            if (exp_c.size() == 0) check("load_c_unexpected", 32'(load_c), 0);
            else check("data_c", 32'(data_c), 32'(exp_c.pop_front()));
         end
      end
      load_a_prev = load_a;
      err_a_prev  = err_a;
      data_a_prev = data_a;
   end

   task automatic drive_a(input logic s, input logic b, input logic e);
      start_a = s; sin_a = b; en_a = e;
      @(posedge clk); #1;
   endtask

   task automatic drive_c(input logic s, input logic b, input logic e);
      start_c = s; sin_c = b; en_c = e;
      @(posedge clk); #1;
   endtask

   // Sends the first nb bits of w, starting from w[7]. When gapped is set,
   // a gap cycle carrying a random sin value precedes each bit.
   task automatic send_a(input logic [7:0] w, input int nb, input bit gapped);
      for (int i = 0; i < nb; i++) begin
         if (gapped) drive_a(1'b0, 1'($urandom_range(0, 1)), 1'b0);
         drive_a(1'b0, w[7-i], 1'b1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] w;
      logic [3:0] w4;

      // Reset for two cycles.
      rst = 1'b1;
      drive_a(1'b0, 1'b0, 1'b0);
      drive_a(1'b0, 1'b0, 1'b0);
      check("rst_data", 32'(data_a), 32'h00);
      check("rst_load", 32'(load_a), 0);
      check("rst_busy", 32'(busy_a), 0);
      check("rst_err", 32'(err_a), 0);
      rst = 1'b0;
      started = 1'b1;

      // Test 1: 0,1,0,1,0,1,0,1 gives 8'h55 MSB-first and 8'hAA LSB-first.
      exp_a.push_back(8'h55); exp_b.push_back(8'hAA);
      drive_a(1'b1, 1'b0, 1'b0);
      check("t1_busy_start", 32'(busy_a), 1);
      w = 8'h55;
      for (int i = 0; i < 8; i++) begin
         drive_a(1'b0, w[7-i], 1'b1);
         if (i < 7) begin
            check("t1_busy_bit", 32'(busy_a), 1);
            check("t1_no_early_load", 32'(load_a), 0);
         end
      end
      check("t1_load", 32'(load_a), 1);
      check("t1_busy_done", 32'(busy_a), 0);
      check("t1_data", 32'(data_a), 32'h55);
      drive_a(1'b0, 1'b0, 1'b0);
      check("t1_load_drop", 32'(load_a), 0);
      check("t1_data_hold", 32'(data_a), 32'h55);
      check("t1_reg", 32'(reg_q), 32'h55);

      // sin_en and sin are ignored in IDLE.
      repeat (3) drive_a(1'b0, 1'b1, 1'b1);
      check("idle_busy", 32'(busy_a), 0);
      check("idle_data", 32'(data_a), 32'h55);

      // Test 2: gapped 8'hAA. The LSB-first DUT assembles 8'h55.
      exp_a.push_back(8'hAA); exp_b.push_back(8'h55);
      drive_a(1'b1, 1'b0, 1'b0);
      send_a(8'hAA, 8, 1'b1);
      check("t2_load", 32'(load_a), 1);
      check("t2_data", 32'(data_a), 32'hAA);
      drive_a(1'b0, 1'b0, 1'b0);
      check("t2_reg", 32'(reg_q), 32'hAA);

      // Test 3: abort after 3 bits. The restart also carries sin_en=1.
      exp_a.push_back(8'hFF); exp_b.push_back(8'hFF);
      drive_a(1'b1, 1'b0, 1'b0);
      send_a(8'hE0, 3, 1'b0);
      drive_a(1'b1, 1'b1, 1'b1);
      check("t3_err", 32'(err_a), 1);
      check("t3_err_b", 32'(err_b), 1);
      check("t3_abort_noload", 32'(load_a), 0);
      check("t3_abort_data", 32'(data_a), 32'hAA);
      check("t3_abort_busy", 32'(busy_a), 1);
      send_a(8'hFF, 8, 1'b0);
      check("t3_err_drop", 32'(err_a), 0);
      check("t3_ff_load", 32'(load_a), 1);
      check("t3_ff_data", 32'(data_a), 32'hFF);
      // Back-to-back: start is sampled during DONE.
      exp_a.push_back(8'h0F); exp_b.push_back(8'hF0);
      drive_a(1'b1, 1'b0, 1'b0);
      check("t3_b2b_busy", 32'(busy_a), 1);
      check("t3_b2b_load_drop", 32'(load_a), 0);
      send_a(8'h0F, 8, 1'b0);
      check("t3_0f_data", 32'(data_a), 32'h0F);
      drive_a(1'b0, 1'b0, 1'b0);
      check("t3_reg", 32'(reg_q), 32'h0F);

      // Test 4: reset mid-frame, then a full 8'hC3.
      drive_a(1'b1, 1'b0, 1'b0);
      send_a(8'hC3, 5, 1'b0);
      rst = 1'b1;
      drive_a(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      check("t4_rst_data", 32'(data_a), 32'h00);
      check("t4_rst_busy", 32'(busy_a), 0);
      check("t4_rst_load", 32'(load_a), 0);
      check("t4_rst_reg", 32'(reg_q), 32'h00);
      exp_a.push_back(8'hC3); exp_b.push_back(8'hC3);
      drive_a(1'b1, 1'b0, 1'b0);
      send_a(8'hC3, 8, 1'b0);
      check("t4_data", 32'(data_a), 32'hC3);
      drive_a(1'b0, 1'b0, 1'b0);

      // Test 5: 1,0,0,0,0,0,0,0 gives 8'h01 LSB-first and 8'h80 MSB-first.
      exp_a.push_back(8'h80); exp_b.push_back(8'h01);
      drive_a(1'b1, 1'b0, 1'b0);
      send_a(8'h80, 8, 1'b0);
      check("t5_data_b", 32'(data_b), 32'h01);
      drive_a(1'b0, 1'b0, 1'b0);
      // N=4, LSB-first: 1,1,0,1 gives 4'hB.
      exp_c.push_back(4'hB);
      drive_c(1'b1, 1'b0, 1'b0);
      w4 = 4'b1101;
      for (int i = 0; i < 4; i++) drive_c(1'b0, w4[3-i], 1'b1);
      check("t5_load_c", 32'(load_c), 1);
      check("t5_data_c", 32'(data_c), 32'hB);
      drive_c(1'b0, 1'b0, 1'b0);

      // Test 6: reset clears both the deserializer and the register.
      rst = 1'b1;
      drive_a(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      check("t6_reg_rst", 32'(reg_q), 32'h00);
      check("t6_data_rst", 32'(data_a), 32'h00);
      repeat (2) drive_a(1'b0, 1'b0, 1'b0);

      check("pending_a", 32'(exp_a.size()), 0);
      check("pending_b", 32'(exp_b.size()), 0);
      check("pending_c", 32'(exp_c.size()), 0);
      check("loads_a", 32'(n_load_a), 6);
      check("loads_b", 32'(n_load_b), 6);
      check("loads_c", 32'(n_load_c), 1);
      check("errs_a", 32'(n_err_a), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
